multu_unit: RTL and testbench

Multi-cycle unsigned multiplier with architectural HI/LO registers. It sits directly downstream of the instruction decoder and consumes its multiply-control outputs:
- domul starts a multu.
- multoreg/lohi read HI or LO back for mfhi/mflo.

It replaces a combinational 32x32 multiplier with a radix-2 shift-add engine of fixed latency. The core stalls on a HI/LO read issued while a multiply is still in flight.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_step.sv | 22 ++
 rtl/multu_unit.sv | 104 ++++++++++
 tb/tb_multu_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multu engine and the decoder that drives it.
//   state_t   : engine FSM states (IDLE accepts a start, RUN iterates)
//   MUL_WIDTH : architectural operand width; HI and LO are each this wide
//   SEL_LO/HI : encoding of the lohi read-select line (shared with decoder)
package mul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MUL_WIDTH = 32;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add iteration of the unsigned multiplier.
// Ports:
//   acc, mcand   : 2*WIDTH-bit accumulator and shifted multiplicand
//   mplier       : WIDTH-bit multiplier shift register
//   acc_nx, mcand_nx, mplier_nx : values after this iteration
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nx,
  output logic [2*WIDTH-1:0] mcand_nx,
  output logic [WIDTH-1:0]   mplier_nx
);

  // Sum wraps mod 2^(2*WIDTH); with unsigned operands it can never carry out.
  assign acc_nx    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_nx  = mcand << 1;
  assign mplier_nx = mplier >> 1;

endmodule

// File: rtl/multu_unit.sv
// Multi-cycle unsigned multiplier with architectural HI/LO registers.
// A start in IDLE captures a and b; the engine then runs exactly WIDTH
// shift-add iterations and commits the full product to HI/LO atomically.
// Ports:
//   clk, reset    : clock; asynchronous active-low reset
//   start, a, b   : multu request and its operands (sampled only on accept)
//   rd_req, lohi  : mfhi/mflo read request and HI/LO select
//   result        : selected HI or LO (combinational from the registers)
//   busy          : multiply in flight
//   stall         : read requested while busy; core must hold
//   done          : one-cycle pulse after HI/LO are committed
module multu_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             lohi,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;

  logic [2*WIDTH-1:0]   acc_nx;
  logic [2*WIDTH-1:0]   mcand_nx;
  logic [WIDTH-1:0]     mplier_nx;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .mcand     (mcand),
    .mplier    (mplier),
    .acc_nx    (acc_nx),
    .mcand_nx  (mcand_nx),
    .mplier_nx (mplier_nx)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values; blocking here would let the commit
  // of hi/lo see a half-updated accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the datapath registers are reset too, so an aborted multiply
      // leaves no partial product behind and HI/LO read as zero.
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
            state  <= RUN;
          end
        end
        RUN: begin
          // A start arriving here is dropped: there is no request queue.
          acc    <= acc_nx;
          mcand  <= mcand_nx;
          mplier <= mplier_nx;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            // Last iteration: commit straight from the step output so the
            // whole product lands in HI and LO on the same edge.
            hi    <= acc_nx[2*WIDTH-1:WIDTH];
            lo    <= acc_nx[WIDTH-1:0];
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state == RUN);
  assign stall  = rd_req & busy;
  assign result = (lohi == SEL_HI) ? hi : lo;

endmodule

// File: tb/tb_multu_unit.sv
// Directed bench for multu_unit: expected {hi,lo} pairs are queued when a
// multiply is started and retired against HI/LO when done pulses.
module tb_multu_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rd_req;
  logic         lohi;
  logic [W-1:0] result;
  logic         busy;
  logic         stall;
  logic         done;

  int vectors = 0;
  int miscompares = 0;

  logic [2*W-1:0] sb_q[$];

  always #5 clk = ~clk;

  multu_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .rd_req (rd_req),
    .lohi   (lohi),
    .result (result),
    .busy   (busy),
    .stall  (stall),
    .done   (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic read_hl(output logic [W-1:0] h, output logic [W-1:0] l);
    lohi = 1'b1;
    #1 h = result;
    lohi = 1'b0;
    #1 l = result;
  endtask

  // Drive a start for one edge and queue the expected product.
  task automatic start_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    sb_q.push_back(p);
    start = 1'b1;
    a = x;
    b = y;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Tick until done, counting cycles from the start edge; retire the
  // scoreboard entry on done. n0 = cycles already elapsed.
  task automatic wait_done(input int n0, output int lat, output int bcnt);
    logic [W-1:0]   h;
    logic [W-1:0]   l;
    logic [2*W-1:0] exp_p;
    int n;
    n = n0;
    bcnt = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) bcnt++;
      tick();
      n++;
    end
    lat = n;
    if (done !== 1'b1) begin
      check("done_timeout", {63'd0, done}, 64'd1);
    end else begin
      read_hl(h, l);
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'd0, 64'd1);
      end else begin
        exp_p = sb_q.pop_front();
        check("sb_hi", {32'd0, h}, {32'd0, exp_p[2*W-1:W]});
        check("sb_lo", {32'd0, l}, {32'd0, exp_p[W-1:0]});
      end
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int done_seen;
    logic [W-1:0] h;
    logic [W-1:0] l;

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    rd_req = 1'b0;
    lohi   = 1'b0;
    tick();
    tick();

    // Reset state
    read_hl(h, l);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, h}, 64'd0);
    check("rst_lo", {32'd0, l}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 3 * 5: busy for 32 cycles, done seen at cycle 33, one-cycle pulse
    start_mul(32'd3, 32'd5);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_done(1, lat, bcnt);
    check("lat_3x5", 64'(lat), 64'd33);
    check("busy_cycles_3x5", 64'(bcnt), 64'd32);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);

    // Stall on read while busy; start during RUN is dropped
    start_mul(32'd7, 32'd6);
    tick(); tick(); tick();            // cycle 4
    start = 1'b1; a = 32'd1; b = 32'd1;
    tick();                            // cycle 5: ignored start
    start = 1'b0;
    tick(); tick(); tick(); tick();    // cycle 9
    rd_req = 1'b1;
    lohi   = 1'b0;
    #1;
    check("stall_busy", {63'd0, stall}, 64'd1);
    check("old_lo_during_run", {32'd0, result}, 64'h0F);
    tick();                            // cycle 10
    wait_done(10, lat, bcnt);
    check("lat_7x6", 64'(lat), 64'd33);
    lohi = 1'b0;
    #1;
    check("stall_released", {63'd0, stall}, 64'd0);
    check("lo_7x6_read", {32'd0, result}, 64'h2A);
    rd_req = 1'b0;
    tick();
    check("no_queued_start", {63'd0, busy}, 64'd0);

    // Boundary operands
    start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, lat, bcnt);
    check("lat_max", 64'(lat), 64'd33);
    tick();
    start_mul(32'h8000_0000, 32'd2);
    wait_done(1, lat, bcnt);
    check("lat_msb", 64'(lat), 64'd33);
    tick();

    // Asynchronous reset mid-multiply aborts it
    start = 1'b1; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    read_hl(h, l);
    check("abort_hi", {32'd0, h}, 64'd0);
    check("abort_lo", {32'd0, l}, 64'd0);
    // Reset wins over a simultaneous start
    start = 1'b1; a = 32'd5; b = 32'd5;
    tick();
    check("reset_beats_start", {63'd0, busy}, 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      tick();
    end
    check("no_done_after_abort", 64'(done_seen), 64'd0);

    // Back-to-back: start accepted in the done cycle
    start_mul(32'd2, 32'd3);
    wait_done(1, lat, bcnt);
    check("lat_2x3", 64'(lat), 64'd33);
    start_mul(32'd4, 32'd5);
    check("b2b_busy", {63'd0, busy}, 64'd1);
    lohi = 1'b0;
    #1;
    check("b2b_lo_held", {32'd0, result}, 64'd6);
    wait_done(1, lat, bcnt);
    check("lat_4x5", 64'(lat), 64'd33);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
